lock_in_sweep_controller: RTL and testbench

Sequencer that drives the lock-in amplifier through a stepped frequency sweep. It programs the reference `period`, waits a settling interval, clears and runs the integration window, then captures the real and imaginary outputs. Each point's result goes out on a valid/ready stream. It sits between the register/config bank and `lock_in_amplifier`, and is the sole owner of that block's `period` input during a sweep.

---
 rtl/opo_package.sv | 16 +
 rtl/cycle_down_counter.sv | 24 ++
 rtl/lock_in_sweep_controller.sv | 183 ++++++++++++++++++
 tb/tb_lock_in_sweep_controller.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/opo_package.sv
// Shared definitions for the OPO lock-in signal chain: register widths and
// the sweep sequencer state encoding.
package opo_package;

    localparam int config_reg_width = 32;
    localparam int word_width       = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_INTEG,
        ST_REPORT,
        ST_DONE
    } sweep_state_t;

endpackage

// File: rtl/cycle_down_counter.sv
// 32-bit loadable down-counter that stops at zero; shared by the settle and
// integration timers of the sweep controller.
module cycle_down_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] value,
    output logic [31:0] count,
    output logic        zero
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - 32'd1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/lock_in_sweep_controller.sv
// Stepped-frequency sweep sequencer for lock_in_amplifier: programs the period,
// settles, clears and integrates, then streams one result per point.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | waiting for start; lia_period keeps its last value
// ST_SETTLE | new period applied, waiting for the lock-in to settle
// ST_INTEG  | integration window running after the accumulator clear
// ST_REPORT | result_valid held until result_ready
// ST_DONE   | one-cycle done pulse, then back to idle
module lock_in_sweep_controller
    import opo_package::*;
#(
    parameter int IDX_W = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        abort,
    input  logic [31:0]                 period_start,
    input  logic [31:0]                 period_step,
    input  logic [IDX_W-1:0]            num_points,
    input  logic [31:0]                 settle_cycles,
    input  logic [31:0]                 integ_cycles,
    output logic [31:0]                 lia_period,
    output logic                        lia_clear,
    input  logic [config_reg_width-1:0] lia_real,
    input  logic [config_reg_width-1:0] lia_imag,
    output logic                        result_valid,
    input  logic                        result_ready,
    output logic [IDX_W-1:0]            result_index,
    output logic [config_reg_width-1:0] result_real,
    output logic [config_reg_width-1:0] result_imag,
    output logic                        busy,
    output logic                        done
);

    sweep_state_t     state;
    logic [31:0]      sh_step;
    logic [31:0]      sh_settle;
    logic [31:0]      sh_integ_m1;
    logic [IDX_W-1:0] sh_last;
    logic [IDX_W-1:0] idx;

    logic             tmr_load;
    logic [31:0]      tmr_value;
    logic [31:0]      tmr_count;
    logic             tmr_zero;
    logic [31:0]      integ_m1;
    logic             last_point;

    // Timer holds "cycles remaining after this one", so a window of N cycles loads N-1.
    assign integ_m1   = (integ_cycles == '0) ? '0 : integ_cycles - 32'd1;
    assign last_point = (idx == sh_last);

    cycle_down_counter u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (tmr_load),
        .value (tmr_value),
        .count (tmr_count),
        .zero  (tmr_zero)
    );

    always_comb begin
        tmr_load  = 1'b0;
        tmr_value = '0;
        if (!abort) begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        tmr_load  = 1'b1;
                        tmr_value = (settle_cycles == '0) ? integ_m1 : settle_cycles - 32'd1;
                    end
                end
                ST_SETTLE: begin
                    if (tmr_zero) begin
                        tmr_load  = 1'b1;
                        tmr_value = sh_integ_m1;
                    end
                end
                // Loading the full settle count gives the extra cycle that applies the new period.
                ST_REPORT: begin
                    if (result_ready && !last_point) begin
                        tmr_load  = 1'b1;
                        tmr_value = sh_settle;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            sh_step      <= '0;
            sh_settle    <= '0;
            sh_integ_m1  <= '0;
            sh_last      <= '0;
            idx          <= '0;
            lia_period   <= '0;
            lia_clear    <= 1'b0;
            result_valid <= 1'b0;
            result_index <= '0;
            result_real  <= '0;
            result_imag  <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            lia_clear <= 1'b0;
            done      <= 1'b0;
            if (abort) begin
                state        <= ST_IDLE;
                result_valid <= 1'b0;
                busy         <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            sh_step     <= period_step;
                            sh_settle   <= settle_cycles;
                            sh_integ_m1 <= integ_m1;
                            sh_last     <= num_points - IDX_W'(1);
                            idx         <= '0;
                            lia_period  <= period_start;
                            busy        <= 1'b1;
                            if (num_points == '0) begin
                                state <= ST_DONE;
                                done  <= 1'b1;
                            end else if (settle_cycles == '0) begin
                                state     <= ST_INTEG;
                                lia_clear <= 1'b1;
                            end else begin
                                state     <= ST_SETTLE;
                                lia_clear <= (settle_cycles == 32'd1);
                            end
                        end
                    end
                    ST_SETTLE: begin
                        if (tmr_zero) begin
                            state <= ST_INTEG;
                        end else if (tmr_count == 32'd1) begin
                            lia_clear <= 1'b1;
                        end
                    end
                    ST_INTEG: begin
                        if (tmr_zero) begin
                            result_real  <= lia_real;
                            result_imag  <= lia_imag;
                            result_index <= idx;
                            result_valid <= 1'b1;
                            state        <= ST_REPORT;
                        end
                    end
                    ST_REPORT: begin
                        if (result_ready) begin
                            result_valid <= 1'b0;
                            if (last_point) begin
                                state <= ST_DONE;
                                done  <= 1'b1;
                            end else begin
                                idx        <= idx + IDX_W'(1);
                                lia_period <= lia_period + sh_step;
                                lia_clear  <= (sh_settle == '0);
                                state      <= ST_SETTLE;
                            end
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lock_in_sweep_controller.sv
// Self-checking bench for lock_in_sweep_controller: a timeline model of the
// sweep checked every cycle, plus directed scenarios with literal expectations.
module tb_lock_in_sweep_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] period_start = '0;
    logic [31:0] period_step = '0;
    logic [15:0] num_points = '0;
    logic [31:0] settle_cycles = '0;
    logic [31:0] integ_cycles = '0;
    logic [31:0] lia_real = '0;
    logic [31:0] lia_imag = '0;
    logic        result_ready = 1'b1;
    logic [31:0] lia_period;
    logic        lia_clear;
    logic        result_valid;
    logic [15:0] result_index;
    logic [31:0] result_real;
    logic [31:0] result_imag;
    logic        busy;
    logic        done;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    // model state: one point at a time, described by the cycle its result appears
    bit          active = 1'b0;
    bit          in_done = 1'b0;
    bit          idle_now;
    logic [31:0] m_step;
    longint      m_num, m_s, m_n, k, valid_at, clear_at;
    logic [31:0] exp_period = '0;
    logic        exp_clear = 1'b0;
    logic        exp_valid = 1'b0;
    logic [15:0] exp_index = '0;
    logic [31:0] exp_real = '0;
    logic [31:0] exp_imag = '0;
    logic        exp_busy = 1'b0;
    logic        exp_done = 1'b0;

    lock_in_sweep_controller #(.IDX_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .period_start  (period_start),
        .period_step   (period_step),
        .num_points    (num_points),
        .settle_cycles (settle_cycles),
        .integ_cycles  (integ_cycles),
        .lia_period    (lia_period),
        .lia_clear     (lia_clear),
        .lia_real      (lia_real),
        .lia_imag      (lia_imag),
        .result_valid  (result_valid),
        .result_ready  (result_ready),
        .result_index  (result_index),
        .result_real   (result_real),
        .result_imag   (result_imag),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, longint act, longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #2;
            lia_real = $urandom;
            lia_imag = $urandom;
        end
    end

    // reference model: inputs as sampled at each edge -> outputs for the following cycle
    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                active = 0; in_done = 0;
                exp_period = '0; exp_clear = 0; exp_valid = 0; exp_index = '0;
                exp_real = '0; exp_imag = '0; exp_busy = 0; exp_done = 0;
            end else begin
                cyc++;
                exp_clear = 0;
                exp_done = 0;
                idle_now = !active && !in_done;
                if (in_done) begin
                    in_done = 0;
                    exp_busy = 0;
                end
                if (abort) begin
                    active = 0; in_done = 0; exp_valid = 0; exp_busy = 0;
                end else if (idle_now && start) begin
                    m_step = period_step;
                    m_num = longint'(num_points);
                    m_s = longint'(settle_cycles);
                    m_n = (integ_cycles == 0) ? 1 : longint'(integ_cycles);
                    k = 0;
                    exp_period = period_start;
                    exp_busy = 1;
                    if (m_num == 0) begin
                        exp_done = 1;
                        in_done = 1;
                    end else begin
                        active = 1;
                        valid_at = (cyc - 1) + m_s + m_n + 1;
                        clear_at = (m_s == 0) ? valid_at - m_n : valid_at - m_n - 1;
                    end
                end else if (active) begin
                    if (exp_valid && result_ready) begin
                        exp_valid = 0;
                        if (k == m_num - 1) begin
                            active = 0;
                            exp_done = 1;
                            in_done = 1;
                        end else begin
                            k++;
                            exp_period = exp_period + m_step;
                            valid_at = (cyc - 1) + m_s + m_n + 2;
                            clear_at = valid_at - m_n - 1;
                        end
                    end else if (!exp_valid && cyc == valid_at) begin
                        exp_valid = 1;
                        exp_index = 16'(k);
                        exp_real = lia_real;
                        exp_imag = lia_imag;
                    end
                end
                if (active && cyc == clear_at) exp_clear = 1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("period", lia_period, exp_period);
                chk("clear", lia_clear, exp_clear);
                chk("valid", result_valid, exp_valid);
                chk("index", result_index, exp_index);
                chk("real", result_real, exp_real);
                chk("imag", result_imag, exp_imag);
                chk("busy", busy, exp_busy);
                chk("done", done, exp_done);
            end
        end
    end

    task automatic pulse_start(output int t1);
        @(posedge clk);
        #2 start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        t1 = cyc;
    endtask

    task automatic wait_valid(input string nm);
        bit ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (result_valid) ok = 1;
        end
        if (!ok) chk(nm, 0, 1);
    endtask

    task automatic wait_idle(input string nm);
        bit ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (!busy) ok = 1;
        end
        if (!ok) chk(nm, 0, 1);
    endtask

    task automatic set_cfg(input logic [31:0] ps, input logic [31:0] st, input logic [15:0] np,
                           input logic [31:0] s, input logic [31:0] n);
        period_start = ps; period_step = st; num_points = np;
        settle_cycles = s; integ_cycles = n;
    endtask

    initial begin
        int t1, nv, dcyc;
        int vc[3];
        logic [31:0] vp[3];
        logic [15:0] vi[3];

        #3 rst = 1'b0;
        chk_en = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_period", lia_period, 0);
        chk("rst_valid", result_valid, 0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;

        // normal sweep
        set_cfg(32'd1000, 32'd10, 16'd3, 32'd4, 32'd8);
        result_ready = 1'b1;
        pulse_start(t1);
        nv = 0; dcyc = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (result_valid && result_ready && nv < 3) begin
                vc[nv] = cyc; vp[nv] = lia_period; vi[nv] = result_index; nv++;
            end
            if (done && dcyc < 0) dcyc = cyc;
        end
        chk("norm_count", nv, 3);
        for (int i = 0; i < 3; i++) begin
            chk("norm_idx", vi[i], i);
            chk("norm_per", vp[i], 1000 + 10 * i);
            chk("norm_vcyc", vc[i], t1 + 12 + 14 * i);
        end
        chk("norm_done", dcyc, t1 + 41);
        chk("norm_busy_end", busy, 0);

        // back-pressure on point 1
        pulse_start(t1);
        wait_valid("bp_to0");
        @(negedge clk);
        result_ready = 1'b0;
        wait_valid("bp_to1");
        for (int i = 0; i < 20; i++) begin
            chk("bp_idx", result_index, 1);
            chk("bp_period", lia_period, 1010);
            chk("bp_valid", result_valid, 1);
            @(negedge clk);
        end
        result_ready = 1'b1;
        wait_idle("bp_idle");

        // zero settle, zero integ, one point
        set_cfg(32'd77, 32'd1, 16'd1, 32'd0, 32'd0);
        pulse_start(t1);
        @(negedge clk);
        chk("edge_clear", lia_clear, 1);
        chk("edge_v_early", result_valid, 0);
        @(negedge clk);
        chk("edge_valid", result_valid, 1);
        chk("edge_index", result_index, 0);
        wait_idle("edge_idle");

        // no points
        num_points = 16'd0;
        pulse_start(t1);
        @(negedge clk);
        chk("np0_done", done, 1);
        chk("np0_busy", busy, 1);
        @(negedge clk);
        chk("np0_done_end", done, 0);
        chk("np0_busy_end", busy, 0);
        chk("np0_valid", result_valid, 0);

        // wrap plus ignored start
        set_cfg(32'hFFFF_FFF0, 32'h20, 16'd2, 32'd3, 32'd2);
        pulse_start(t1);
        @(posedge clk);
        #2 period_start = 32'd5; start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        @(negedge clk);
        chk("ign_period", lia_period, 32'hFFFF_FFF0);
        wait_valid("wrap_to");
        @(negedge clk);
        chk("wrap_period", lia_period, 32'h10);
        wait_idle("wrap_idle");

        // abort in REPORT
        set_cfg(32'd500, 32'd3, 16'd3, 32'd1, 32'd1);
        result_ready = 1'b0;
        pulse_start(t1);
        wait_valid("abort_to");
        @(posedge clk);
        #2 abort = 1'b1;
        @(posedge clk);
        #2 abort = 1'b0;
        @(negedge clk);
        chk("abort_valid", result_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_period", lia_period, 500);
        result_ready = 1'b1;

        // reset during INTEG, then a clean sweep
        set_cfg(32'd900, 32'd1, 16'd2, 32'd2, 32'd10);
        pulse_start(t1);
        repeat (5) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_period", lia_period, 0);
        chk("mid_rst_clear", lia_clear, 0);
        chk("mid_rst_valid", result_valid, 0);
        @(posedge clk);
        #2 rst = 1'b1;
        set_cfg(32'd42, 32'd1, 16'd1, 32'd1, 32'd1);
        pulse_start(t1);
        wait_valid("post_rst_to");
        chk("post_rst_vcyc", cyc, t1 + 2);
        chk("post_rst_period", lia_period, 42);
        wait_idle("post_rst_idle");

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #2;
            start = ($urandom_range(0, 7) == 0);
            abort = ($urandom_range(0, 59) == 0);
            result_ready = ($urandom_range(0, 3) != 0);
            period_start = $urandom;
            period_step = $urandom;
            num_points = 16'($urandom_range(0, 4));
            settle_cycles = $urandom_range(0, 4);
            integ_cycles = $urandom_range(0, 4);
        end
        @(posedge clk);
        #2 start = 1'b0; abort = 1'b0; result_ready = 1'b1;
        wait_idle("rand_idle");
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
